// File: rtl/gf_stripe_sched.sv
// Purpose: splits a frame into vertical stripes and feeds clamped, padded pixel read addresses to the guided filter; counts results and writes them back.
// Latency: dp_clear appears 1 cycle after start; the first pix_valid follows 1 cycle later. out_we/out_addr are same-cycle with dp_valid_out.
// Backpressure: pix_addr holds while dp_ready=0. There is no backpressure on results; unexpected results set sticky err.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          frame start pulse (accepted only when idle)
//   dp_ready       datapath accepts the offered pixel
//   dp_valid_out   datapath result strobe
//   dp_clear       one-cycle datapath clear before each stripe
//   pix_valid      pixel read address offered
//   pix_addr       input-frame read address
//   out_we         output-frame write enable
//   out_addr       output-frame write address
//   stripe_idx     current stripe
//   busy           high whenever not idle
//   done           one-cycle end-of-frame pulse
//   err            sticky unexpected-result flag
module gf_stripe_sched #(
  parameter int FRAME_W     = 1920,
  parameter int FRAME_H     = 1080,
  parameter int STRIPEWIDTH = 120,
  parameter int ALPHA       = 15,
  parameter int NUMOFCOLS   = STRIPEWIDTH + 4*ALPHA,
  parameter int NUMOFROWS   = FRAME_H + ALPHA,
  parameter int NSTRIPE     = FRAME_W / STRIPEWIDTH,
  parameter int AW          = $clog2(FRAME_W*FRAME_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dp_ready,
  input  logic                       dp_valid_out,
  output logic                       dp_clear,
  output logic                       pix_valid,
  output logic [AW-1:0]              pix_addr,
  output logic                       out_we,
  output logic [AW-1:0]              out_addr,
  output logic [$clog2(NSTRIPE):0]   stripe_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int CW    = $clog2(FRAME_W + 4*ALPHA) + 1;  // signed column width
  localparam int RW    = $clog2(NUMOFROWS + 1);
  localparam int OCW   = $clog2(STRIPEWIDTH + 1);
  localparam int TOTAL = FRAME_H * STRIPEWIDTH;            // results per stripe
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int SW    = $clog2(NSTRIPE) + 1;

  localparam logic signed [CW-1:0] COL_MAX = CW'(FRAME_W - 1);
  localparam logic signed [CW-1:0] PAD     = CW'(2*ALPHA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_NEXT
  } state_t;

  state_t state;

  // Input sweep: row base tracks min(in_row, FRAME_H-1)*FRAME_W incrementally.
  logic [RW-1:0]  in_row;
  logic [CW-1:0]  in_col;
  logic [AW-1:0]  in_row_base;
  // Result sweep.
  logic [OCW-1:0] out_col;
  logic [AW-1:0]  out_row_base;
  logic [NW-1:0]  out_cnt;
  // Left output column of the current stripe.
  logic [CW-1:0]  x0;

  logic signed [CW-1:0] col_raw;
  logic [CW-1:0]        col_c;
  logic counting, cnt_full, counted, last_result, bad_result;
  logic fire, last_pix, last_stripe;

  always_comb begin
    col_raw = $signed(x0 + in_col) - PAD;
    // Clamp gives edge replication on the left and right borders.
    if (col_raw[CW-1])
      col_c = '0;
    else if (col_raw > COL_MAX)
      col_c = CW'(FRAME_W - 1);
    else
      col_c = $unsigned(col_raw);
  end

  assign pix_addr    = in_row_base + AW'(col_c);
  assign out_addr    = out_row_base + AW'(x0) + AW'(out_col);

  assign counting    = (state == S_FEED) || (state == S_DRAIN);
  assign cnt_full    = (out_cnt == NW'(TOTAL));
  assign counted     = dp_valid_out && counting && !cnt_full;
  assign last_result = counted && (out_cnt == NW'(TOTAL - 1));
  assign bad_result  = dp_valid_out && !counted;
  assign out_we      = counted;

  assign fire        = pix_valid && dp_ready;
  assign last_pix    = (in_row == RW'(NUMOFROWS - 1)) && (in_col == CW'(NUMOFCOLS - 1));
  assign last_stripe = (stripe_idx == SW'(NSTRIPE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dp_clear     <= 1'b0;
      pix_valid    <= 1'b0;
      stripe_idx   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      in_row       <= '0;
      in_col       <= '0;
      in_row_base  <= '0;
      out_col      <= '0;
      out_row_base <= '0;
      out_cnt      <= '0;
      x0           <= '0;
    end else begin
      // A bad result on the same cycle as start still flags.
      if (bad_result)
        err <= 1'b1;
      else if (state == S_IDLE && start)
        err <= 1'b0;

      if (counted) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_col == OCW'(STRIPEWIDTH - 1)) begin
          out_col      <= '0;
          out_row_base <= out_row_base + AW'(FRAME_W);
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      if (fire) begin
        if (in_col == CW'(NUMOFCOLS - 1)) begin
          in_col <= '0;
          in_row <= in_row + 1'b1;
          // Flush rows past the bottom reuse the last frame row.
          if (in_row < RW'(FRAME_H - 1))
            in_row_base <= in_row_base + AW'(FRAME_W);
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            stripe_idx <= '0;
            x0         <= '0;
            dp_clear   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_CLEAR: begin
          // No pixels or counted results can occur here, so clearing is safe.
          dp_clear     <= 1'b0;
          pix_valid    <= 1'b1;
          in_row       <= '0;
          in_col       <= '0;
          in_row_base  <= '0;
          out_col      <= '0;
          out_row_base <= '0;
          out_cnt      <= '0;
          state        <= S_FEED;
        end
        S_FEED: begin
          // All results in means the stripe is done even if feeding is not.
          if (last_result) begin
            state     <= S_NEXT;
            pix_valid <= 1'b0;
            done      <= last_stripe;
          end else if (fire && last_pix) begin
            state     <= S_DRAIN;
            pix_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (last_result) begin
            state <= S_NEXT;
            done  <= last_stripe;
          end
        end
        S_NEXT: begin
          done <= 1'b0;
          if (last_stripe) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            stripe_idx <= stripe_idx + 1'b1;
            x0         <= x0 + CW'(STRIPEWIDTH);
            dp_clear   <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_stripe_sched.sv
module tb_gf_stripe_sched;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dp_ready = 1'b0;
  logic          dp_valid_out = 1'b0;
  logic          dp_clear;
  logic          pix_valid;
  logic [AW-1:0] pix_addr;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [1:0]    stripe_idx;
  logic          busy;
  logic          done;
  logic          err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  gf_stripe_sched #(
    .FRAME_W(8), .FRAME_H(4), .STRIPEWIDTH(4), .ALPHA(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dp_ready(dp_ready),
    .dp_valid_out(dp_valid_out), .dp_clear(dp_clear), .pix_valid(pix_valid),
    .pix_addr(pix_addr), .out_we(out_we), .out_addr(out_addr),
    .stripe_idx(stripe_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Expected read address of the k-th pixel of stripe s (8 cols/row, pad 2).
  function automatic logic [AW-1:0] exp_pix(input int s, input int k);
    int r, c, raw;
    r   = k / 8;
    c   = k % 8;
    raw = s*4 - 2 + c;
    if (raw < 0) raw = 0;
    if (raw > 7) raw = 7;
    if (r > 3) r = 3;
    return AW'(r*8 + raw);
  endfunction

  // Expected write address of the r-th result of stripe s.
  function automatic logic [AW-1:0] exp_out(input int s, input int r);
    return AW'((r/4)*8 + s*4 + r%4);
  endfunction

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_stripe(input int s, input bit rnd);
    int n = 0;
    int budget = 0;
    bit held = 1'b0;
    logic [AW-1:0] prev = '0;
    while (!pix_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    budget = 0;
    while (pix_valid && budget < 500) begin
      if (held) begin
        chk_cnt++;
        if (pix_addr !== prev)
          $display("FAIL pix_hold s%0d n%0d got %0d want %0d", s, n, pix_addr, prev);
        else pass_cnt++;
      end
      dp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dp_ready) begin
        chk_cnt++;
        if (pix_addr !== exp_pix(s, n))
          $display("FAIL pix_addr s%0d n%0d got %0d want %0d", s, n, pix_addr, exp_pix(s, n));
        else pass_cnt++;
        n++;
      end
      held = !dp_ready;
      prev = pix_addr;
      @(negedge clk);
      budget++;
    end
    dp_ready = 1'b0;
    chk_cnt++;
    if (n !== 40) $display("FAIL pix_count s%0d got %0d want 40", s, n);
    else pass_cnt++;
  endtask

  task automatic return_results(input int s);
    for (int r = 0; r < 16; r++) begin
      dp_valid_out = 1'b1;
      #1;
      chk_cnt++;
      if (out_we !== 1'b1) $display("FAIL out_we s%0d r%0d got %b want 1", s, r, out_we);
      else pass_cnt++;
      chk_cnt++;
      if (out_addr !== exp_out(s, r))
        $display("FAIL out_addr s%0d r%0d got %0d want %0d", s, r, out_addr, exp_out(s, r));
      else pass_cnt++;
      @(negedge clk);
    end
    dp_valid_out = 1'b0;
  endtask

  task automatic wait_idle;
    int b = 0;
    while (busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL wait_idle busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({dp_clear, pix_valid, pix_addr, out_we, out_addr, stripe_idx, busy, done, err} !== 18'h0)
      $display("FAIL reset_outputs got %h want 0",
               {dp_clear, pix_valid, pix_addr, out_we, out_addr, stripe_idx, busy, done, err});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({busy, pix_valid, dp_clear} !== 3'b000)
      $display("FAIL reset_idle got %b want 000", {busy, pix_valid, dp_clear});
    else pass_cnt++;
  endtask

  task automatic test_full_frame;
    do_start;
    chk_cnt++;
    if ({dp_clear, busy, pix_valid} !== 3'b110)
      $display("FAIL clear_pulse got %b want 110", {dp_clear, busy, pix_valid});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({dp_clear, pix_valid} !== 2'b01)
      $display("FAIL feed_entry got %b want 01", {dp_clear, pix_valid});
    else pass_cnt++;
    feed_stripe(0, 1'b0);
    chk_cnt++;
    if ({pix_valid, busy} !== 2'b01) $display("FAIL drain_state got %b want 01", {pix_valid, busy});
    else pass_cnt++;
    return_results(0);
    chk_cnt++;
    if ({done, stripe_idx} !== 3'b000) $display("FAIL next_s0 got %b want 000", {done, stripe_idx});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({dp_clear, stripe_idx} !== 3'b101) $display("FAIL clear_s1 got %b want 101", {dp_clear, stripe_idx});
    else pass_cnt++;
    feed_stripe(1, 1'b0);
    return_results(1);
    chk_cnt++;
    if ({done, busy} !== 2'b11) $display("FAIL done_pulse got %b want 11", {done, busy});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL done_end got %b want 00", {done, busy});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL done_once got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    do_start;
    feed_stripe(0, 1'b1);
    return_results(0);
    feed_stripe(1, 1'b1);
    return_results(1);
    wait_idle;
  endtask

  task automatic test_early_completion;
    do_start;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      dp_ready     = 1'b1;
      dp_valid_out = (k >= 14);
      #1;
      chk_cnt++;
      if (pix_addr !== exp_pix(0, k) || pix_valid !== 1'b1)
        $display("FAIL early_pix k%0d got %0d/%b want %0d/1", k, pix_addr, pix_valid, exp_pix(0, k));
      else pass_cnt++;
      if (k >= 14) begin
        chk_cnt++;
        if (out_we !== 1'b1 || out_addr !== exp_out(0, k - 14))
          $display("FAIL early_out k%0d got %b/%0d want 1/%0d", k, out_we, out_addr, exp_out(0, k - 14));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    dp_ready     = 1'b0;
    dp_valid_out = 1'b0;
    chk_cnt++;
    if ({pix_valid, busy, dp_clear} !== 3'b010)
      $display("FAIL early_next got %b want 010", {pix_valid, busy, dp_clear});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({dp_clear, stripe_idx} !== 3'b101) $display("FAIL early_clear got %b want 101", {dp_clear, stripe_idx});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (pix_valid !== 1'b1 || pix_addr !== 5'd2)
      $display("FAIL early_s1_first got %b/%0d want 1/2", pix_valid, pix_addr);
    else pass_cnt++;
    feed_stripe(1, 1'b0);
    return_results(1);
    wait_idle;
  endtask

  task automatic test_errors;
    dp_valid_out = 1'b1;
    #1;
    chk_cnt++;
    if (out_we !== 1'b0) $display("FAIL idle_out_we got %b want 0", out_we);
    else pass_cnt++;
    @(negedge clk);
    dp_valid_out = 1'b0;
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL idle_err got %b want 1", err);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err);
    else pass_cnt++;
    do_start;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL start_clears_err got %b want 0", err);
    else pass_cnt++;
    dp_valid_out = 1'b1;
    #1;
    chk_cnt++;
    if (out_we !== 1'b0) $display("FAIL clear_out_we got %b want 0", out_we);
    else pass_cnt++;
    @(negedge clk);
    dp_valid_out = 1'b0;
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL clear_err got %b want 1", err);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      chk_cnt++;
      if (pix_addr !== exp_pix(0, k))
        $display("FAIL busy_start_pix k%0d got %0d want %0d", k, pix_addr, exp_pix(0, k));
      else pass_cnt++;
      dp_ready = 1'b1;
      start    = (k == 2);
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        chk_cnt++;
        if ({dp_clear, pix_valid, stripe_idx} !== 4'b0100)
          $display("FAIL start_ignored got %b want 0100", {dp_clear, pix_valid, stripe_idx});
        else pass_cnt++;
      end
    end
    dp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({dp_clear, pix_valid, pix_addr, out_we, out_addr, stripe_idx, busy, done, err} !== 18'h0)
      $display("FAIL async_reset got %h want 0",
               {dp_clear, pix_valid, pix_addr, out_we, out_addr, stripe_idx, busy, done, err});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start;
    chk_cnt++;
    if ({dp_clear, err, stripe_idx} !== 4'b1000)
      $display("FAIL restart got %b want 1000", {dp_clear, err, stripe_idx});
    else pass_cnt++;
    feed_stripe(0, 1'b0);
    return_results(0);
    feed_stripe(1, 1'b0);
    return_results(1);
    chk_cnt++;
    if (done !== 1'b1) $display("FAIL restart_done got %b want 1", done);
    else pass_cnt++;
    wait_idle;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL restart_err got %b want 0", err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_backpressure;
    test_early_completion;
    test_errors;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
